// File: rtl/psd_range_accumulator.sv
// psd_range_accumulator: sums NOF_BINS frames per pulse over acc_count pulses
// into an internal RAM, then streams the totals out with valid/ready.
// Ports: clk_i, rst_n_i (sync, active-low), start_i, abort_i, acc_count_i;
//   psd_valid_i/psd_sop_i/psd_data_i in; out_valid_o/out_ready_i/out_data_o/
//   out_last_o out; busy_o, done_o, sync_err_o, ovf_o status.
// Build option: define PSD_ACC_SATURATE_EN to saturate sums and drive ovf_o.
module psd_range_accumulator #(
  parameter int DATA_W       = 32,
  parameter int ACC_W        = 48,
  parameter int FFT_LEN_LOG2 = 10,
  parameter int NOF_BINS     = 16,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  acc_count_i,
  input  logic              psd_valid_i,
  input  logic              psd_sop_i,
  input  logic [DATA_W-1:0] psd_data_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [ACC_W-1:0]  out_data_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              sync_err_o,
  output logic              ovf_o
);
  localparam int BIN_W  = (NOF_BINS > 1) ? $clog2(NOF_BINS) : 1;
  localparam int ADDR_W = $clog2(NOF_BINS) + FFT_LEN_LOG2;
  localparam int DEPTH  = NOF_BINS << FFT_LEN_LOG2;
  localparam int RW     = ADDR_W + 1;
  localparam int FL     = FFT_LEN_LOG2;

  typedef enum logic [2:0] {
    IDLE, WAIT_SOP, ACCUM, DRAIN, READOUT
  } state_t;

  state_t state;

  logic [ACC_W-1:0]  ram [DEPTH];
  logic [CNT_W-1:0]  target;
  logic [CNT_W-1:0]  pulse;
  logic [BIN_W-1:0]  bin;
  logic [FL-1:0]     point;
  logic              sync_err;
  logic              done;

  logic              s1_v, s1_first;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;
  logic [ACC_W-1:0]  rd_q;
  logic              s2_v;
  logic [ADDR_W-1:0] s2_addr;
  logic [ACC_W-1:0]  s2_sum;

  logic [RW-1:0]     rd_addr;
  logic [1:0]        cnt;
  logic              wp, rp;
  logic [ACC_W-1:0]  fifo_d [2];
  logic [1:0]        fifo_l;

  logic              take, resync;
  logic              pt_wrap, bin_wrap, run_end;
  logic [FL-1:0]     pt;
  logic [ADDR_W-1:0] acc_addr;
  logic              issue, pop;
  logic [ACC_W-1:0]  sum;

  // a sop always restarts the frame at point 0 of the current bin
  assign take = psd_valid_i && !abort_i &&
    ((state == WAIT_SOP && psd_sop_i) || state == ACCUM);
  assign resync   = state == ACCUM && psd_sop_i && point != '0;
  assign pt       = psd_sop_i ? '0 : point;
  assign acc_addr = ADDR_W'({bin, pt});
  assign pt_wrap  = &pt;
  assign bin_wrap = bin == BIN_W'(NOF_BINS - 1);
  assign run_end  = pt_wrap && bin_wrap &&
    pulse == target - CNT_W'(1);

  assign out_valid_o = state == READOUT && cnt != 2'd0;
  assign out_data_o  = fifo_d[rp];
  assign out_last_o  = out_valid_o && fifo_l[rp];
  assign pop         = out_valid_o && out_ready_i;
  // prefetch keeps at most two words in flight
  assign issue = state == READOUT &&
    rd_addr != RW'(DEPTH) && (cnt != 2'd2 || pop);

  assign busy_o     = state != IDLE;
  assign done_o     = done;
  assign sync_err_o = sync_err;

`ifdef PSD_ACC_SATURATE_EN
  localparam int SW = ACC_W + 1;
  logic [SW-1:0] sum_full;
  logic          sat;
  logic          ovf;

  always_comb begin
    sum      = ACC_W'(s1_data);
    sat      = 1'b0;
    sum_full = {1'b0, rd_q} + SW'(s1_data);
    if (!s1_first) begin
      if (sum_full[ACC_W]) begin
        sum = '1;
        sat = 1'b1;
      end else begin
        sum = sum_full[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)
      ovf <= 1'b0;
    else if (state == IDLE && start_i && !abort_i)
      ovf <= 1'b0;
    else if (s1_v && sat)
      ovf <= 1'b1;
  end

  assign ovf_o = ovf;
`else
  always_comb begin
    sum = ACC_W'(s1_data);
    if (!s1_first)
      sum = rd_q + ACC_W'(s1_data);
  end

  assign ovf_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (s2_v)
      ram[s2_addr] <= s2_sum;
    rd_q <= ram[acc_addr];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      target    <= '0;
      pulse     <= '0;
      bin       <= '0;
      point     <= '0;
      sync_err  <= 1'b0;
      done      <= 1'b0;
      s1_v      <= 1'b0;
      s1_first  <= 1'b0;
      s1_addr   <= '0;
      s1_data   <= '0;
      s2_v      <= 1'b0;
      s2_addr   <= '0;
      s2_sum    <= '0;
      rd_addr   <= '0;
      cnt       <= '0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      fifo_d[0] <= '0;
      fifo_d[1] <= '0;
      fifo_l    <= '0;
    end else begin
      done     <= 1'b0;
      s1_v     <= take;
      s1_first <= pulse == '0;
      s1_addr  <= acc_addr;
      s1_data  <= psd_data_i;
      s2_v     <= s1_v;
      s2_addr  <= s1_addr;
      s2_sum   <= sum;
      if (abort_i) begin
        state <= IDLE;
        cnt   <= '0;
        s1_v  <= 1'b0;
        s2_v  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_i) begin
              state    <= WAIT_SOP;
              target   <= (acc_count_i == '0) ?
                          CNT_W'(1) : acc_count_i;
              pulse    <= '0;
              bin      <= '0;
              point    <= '0;
              sync_err <= 1'b0;
            end
          end
          WAIT_SOP, ACCUM: begin
            if (take) begin
              if (resync)
                sync_err <= 1'b1;
              point <= pt + FL'(1);
              if (pt_wrap) begin
                bin <= bin_wrap ? '0 : bin + BIN_W'(1);
                if (bin_wrap)
                  pulse <= pulse + CNT_W'(1);
              end
              state <= run_end ? DRAIN : ACCUM;
            end
          end
          DRAIN: begin
            // last write lands on the edge that leaves DRAIN
            if (!s1_v) begin
              state   <= READOUT;
              rd_addr <= '0;
              cnt     <= '0;
              wp      <= 1'b0;
              rp      <= 1'b0;
            end
          end
          READOUT: begin
            if (issue) begin
              fifo_d[wp] <= ram[rd_addr[ADDR_W-1:0]];
              fifo_l[wp] <= rd_addr == RW'(DEPTH - 1);
              wp         <= ~wp;
              rd_addr    <= rd_addr + RW'(1);
            end
            if (pop)
              rp <= ~rp;
            cnt <= cnt + {1'b0, issue} - {1'b0, pop};
            if (pop && fifo_l[rp]) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_psd_range_accumulator.sv
// Bench for psd_range_accumulator: random and directed runs against a
// frame-level reference sum, plus a narrow instance for the overflow rule.
module tb_psd_range_accumulator;
  localparam int DW = 32;
  localparam int AW = 48;
  localparam int L  = 3;
  localparam int NB = 2;
  localparam int CW = 16;
  localparam int PTS   = 1 << L;
  localparam int DEPTH = NB * PTS;

`ifdef PSD_ACC_SATURATE_EN
  localparam logic [7:0] OVF_DATA = 8'd255;
  localparam logic       OVF_FLAG = 1'b1;
`else
  localparam logic [7:0] OVF_DATA = 8'd144;
  localparam logic       OVF_FLAG = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] acc_count = '0;
  logic          psd_valid = 1'b0;
  logic          psd_sop = 1'b0;
  logic [DW-1:0] psd_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid, out_last, busy, done, sync_err, ovf;
  logic [AW-1:0] out_data;

  logic          s_start = 1'b0;
  logic [CW-1:0] s_count = '0;
  logic          s_valid = 1'b0;
  logic          s_sop = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_ready = 1'b0;
  logic          s_out_valid, s_out_last, s_busy, s_done;
  logic          s_sync_err, s_ovf;
  logic [7:0]    s_out_data;

  int total = 0;
  int passed = 0;
  int fails = 0;
  logic [AW-1:0] model [DEPTH];

  psd_range_accumulator #(
    .DATA_W(DW), .ACC_W(AW), .FFT_LEN_LOG2(L),
    .NOF_BINS(NB), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .abort_i(abort), .acc_count_i(acc_count),
    .psd_valid_i(psd_valid), .psd_sop_i(psd_sop),
    .psd_data_i(psd_data), .out_ready_i(out_ready),
    .out_valid_o(out_valid), .out_data_o(out_data),
    .out_last_o(out_last), .busy_o(busy), .done_o(done),
    .sync_err_o(sync_err), .ovf_o(ovf)
  );

  psd_range_accumulator #(
    .DATA_W(8), .ACC_W(8), .FFT_LEN_LOG2(1),
    .NOF_BINS(2), .CNT_W(CW)
  ) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(s_start),
    .abort_i(1'b0), .acc_count_i(s_count),
    .psd_valid_i(s_valid), .psd_sop_i(s_sop),
    .psd_data_i(s_data), .out_ready_i(s_ready),
    .out_valid_o(s_out_valid), .out_data_o(s_out_data),
    .out_last_o(s_out_last), .busy_o(s_busy), .done_o(s_done),
    .sync_err_o(s_sync_err), .ovf_o(s_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sop, input logic [DW-1:0] d);
    psd_valid = 1'b1;
    psd_sop   = sop;
    psd_data  = d;
    tick();
    psd_valid = 1'b0;
    psd_sop   = 1'b0;
  endtask

  task automatic gap();
    psd_data = $urandom;
    psd_sop  = 1'($urandom_range(0, 1));
    tick();
    psd_sop  = 1'b0;
  endtask

  task automatic do_start(input logic [CW-1:0] n);
    chk("idle_busy", busy, 0);
    acc_count = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  // kind 0: data 10*bin+point+1; 1: random; 2: random with a
  // partial bin-0 frame (points 0..4) inserted in pulse 2
  task automatic run_accum(input int pulses, input int kind,
                           input bit ign);
    logic [DW-1:0] d;
    logic          sop;
    for (int i = 0; i < 3; i++)
      send(1'b0, $urandom);
    for (int p = 0; p < pulses; p++) begin
      for (int b = 0; b < NB; b++) begin
        if (kind == 2 && p == 2 && b == 0) begin
          for (int q = 0; q < 5; q++) begin
            d = $urandom;
            send(q == 0, d);
            model[b*PTS+q] += AW'(d);
          end
        end
        for (int q = 0; q < PTS; q++) begin
          d = (kind == 0) ? DW'(10*b + q + 1) : $urandom;
          sop = (q == 0) && ((p == 0 && b == 0) ||
                (kind == 2 && p == 2 && b == 0) ||
                $urandom_range(0, 1) == 1);
          if (kind != 0 && $urandom_range(0, 3) == 0)
            gap();
          if (ign && p == 1 && b == 0 && q == 0) begin
            start = 1'b1;
            acc_count = 16'd7;
          end
          send(sop, d);
          start = 1'b0;
          if (p == 0)
            model[b*PTS+q] = AW'(d);
          else
            model[b*PTS+q] += AW'(d);
        end
      end
    end
  endtask

  task automatic wait_first(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      psd_valid = 1'b1;
      psd_sop   = 1'b1;
      psd_data  = $urandom;
      tick();
      n++;
    end
    psd_valid = 1'b0;
    psd_sop   = 1'b0;
    chk({tag, "_latency"}, n, 3);
  endtask

  task automatic collect(input bit bp, input string tag);
    int idx = 0;
    bit held = 0;
    logic [AW-1:0] hd = '0;
    logic hl = 1'b0;
    for (int c = 0; c < 400 && idx < DEPTH; c++) begin
      if (held) begin
        chk({tag, "_hold_v"}, out_valid, 1);
        chk({tag, "_hold_d"}, out_data, hd);
        chk({tag, "_hold_l"}, out_last, hl);
      end
      out_ready = !bp || (c % 3 == 0);
      held = 0;
      if (out_valid) begin
        if (out_ready) begin
          chk({tag, "_data"}, out_data, model[idx]);
          chk({tag, "_last"}, out_last, idx == DEPTH - 1);
          chk({tag, "_done_early"}, done, 0);
          idx++;
        end else begin
          held = 1;
          hd = out_data;
          hl = out_last;
        end
      end
      tick();
    end
    out_ready = 1'b0;
    chk({tag, "_words"}, idx, DEPTH);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_fall"}, busy, 0);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_valid_idle"}, out_valid, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sync", sync_err, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_s_busy", s_busy, 0);
    rst_n = 1'b1;
    tick();

    do_start(16'd4);
    run_accum(4, 0, 1);
    chk("ign_start_busy", busy, 1);
    wait_first("basic");
    collect(0, "basic");
    chk("basic_sync", sync_err, 0);

    do_start(16'd4);
    run_accum(4, 0, 0);
    wait_first("bp");
    collect(1, "bp");

    do_start(16'd4);
    run_accum(4, 2, 0);
    chk("frame_sync", sync_err, 1);
    wait_first("frame");
    collect(0, "frame");

    do_start(16'd0);
    chk("start_clr_sync", sync_err, 0);
    run_accum(1, 1, 0);
    wait_first("acc0");
    collect(0, "acc0");

    do_start(16'd1);
    run_accum(1, 1, 0);
    wait_first("abort");
    out_ready = 1'b1;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_last", out_last, 0);

    do_start(16'd3);
    for (int q = 0; q < PTS; q++)
      send(q == 0, $urandom);
    for (int q = 0; q < 3; q++)
      send(1'b0, $urandom);
    send(1'b1, $urandom);
    chk("pre_rst_sync", sync_err, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sync", sync_err, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();
    do_start(16'd2);
    run_accum(2, 1, 0);
    wait_first("fresh");
    collect(0, "fresh");
    chk("fresh_sync", sync_err, 0);

    s_count = 16'd2;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        s_valid = 1'b1;
        s_sop   = (i == 0);
        s_data  = 8'd200;
        tick();
      end
    end
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_ready = 1'b1;
    begin
      int got = 0;
      for (int c = 0; c < 30 && got < 4; c++) begin
        if (s_out_valid) begin
          chk("ovf_data", s_out_data, OVF_DATA);
          chk("ovf_last", s_out_last, got == 3);
          got++;
        end
        tick();
      end
      chk("ovf_words", got, 4);
    end
    s_ready = 1'b0;
    chk("ovf_flag", s_ovf, OVF_FLAG);
    chk("ovf_done", s_done, 1);
    chk("ovf_sync", s_sync_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/psd_range_accumulator.md
# psd_range_accumulator

Parametrised power-spectrum accumulator that sits after the power-spectrum calculator in the user-logic signal-processing chain. It replaces the fixed 16-range-bin by 1024-point accumulator with a self-contained block. Per laser pulse, it sums `NOF_BINS` consecutive FFT frames into an internal RAM. After a run-time number of pulses it streams out the accumulated spectra with valid/ready backpressure. It owns the range-bin counter, the pulse counter and the read-modify-write pipeline.

## Interface
- `DATA_W`, 32: width of an incoming power-spectrum sample (unsigned).
- `ACC_W`, 48: accumulator word width; must be ≥ `DATA_W`.
- `FFT_LEN_LOG2`, 10: log2 of the number of points per frame.
- `NOF_BINS`, 16: range bins per pulse, 1..64.
- `CNT_W`, 16: width of the pulse-count input.
- Derived: `ADDR_W` = clog2(`NOF_BINS`) + `FFT_LEN_LOG2`.
- `clk_i` in 1: sole clock.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `start_i` in 1: pulse; arms a new accumulation run (IDLE only).
- `abort_i` in 1: pulse; returns to IDLE from any state.
- `acc_count_i` in `CNT_W`: pulses to accumulate; sampled on start; 0 is treated as 1.
- `psd_valid_i` in 1: spectrum sample valid.
- `psd_sop_i` in 1: first sample of a frame (qualified by valid).
- `psd_data_i` in `DATA_W`: power-spectrum sample.
- `out_ready_i` in 1: downstream ready.
- `out_valid_o` out 1: readout word valid.
- `out_data_o` out `ACC_W`: accumulated word.
- `out_last_o` out 1: final word of readout.
- `busy_o` out 1: state ≠ IDLE.
- `done_o` out 1: one-cycle pulse when readout completes.
- `sync_err_o` out 1: sticky; frame framing error seen; cleared on start.
- `ovf_o` out 1: sticky; accumulator overflow (see Configuration); cleared on start.

## Operation
- States: IDLE, WAIT_SOP, ACCUM, DRAIN, READOUT.
- IDLE → WAIT_SOP on `start_i`:
  - latch `acc_count_i`;
  - clear the pulse counter, bin counter, point counter and sticky flags.
- WAIT_SOP: valid samples without sop are discarded. A valid sample with sop enters ACCUM and is processed as point 0 of bin 0.
- ACCUM:
  - Each valid sample addresses RAM at {bin, point}.
  - On the first pulse (pulse counter = 0), the sample is written zero-extended; otherwise it is added to the stored word.
  - The point counter wraps at 2^`FFT_LEN_LOG2`. The bin increments on wrap. The bin wraps at `NOF_BINS`, and the pulse counter then increments.
  - Framing: a sop while point ≠ 0 sets `sync_err_o`. The partial frame is abandoned: the point is reset to 0 and that sample is processed as point 0 of the same bin.
  - A frame lacking sop at point 0 is accepted.
- After the last sample of the last bin of pulse `acc_count`: ACCUM → DRAIN. Further input is ignored until the next start.
- DRAIN: waits until the write pipeline is empty (2 cycles), then enters READOUT.
- READOUT:
  - Addresses 0..`NOF_BINS`·2^`FFT_LEN_LOG2`−1 are streamed in order, bin-major.
  - A word transfers when `out_valid_o` && `out_ready_i`.
  - `out_last_o` is set on the final word. `done_o` pulses the cycle after that transfer, and the state returns to IDLE.
- `start_i` outside IDLE is ignored.
- `abort_i` has priority over all other events in the same cycle. It drops `out_valid_o` next cycle; RAM contents are undefined afterwards.
- RAW hazard: consecutive accesses to the same address are at least `NOF_BINS`·2^`FFT_LEN_LOG2` samples apart. No forwarding is required; `NOF_BINS`·2^`FFT_LEN_LOG2` ≥ 4 is a legal-config rule.

## Timing
- Reset (`rst_n_i`=0 at a clock edge): state IDLE; all outputs 0; counters 0.
- Accumulate pipeline:
  - cycle 0: sample accepted, RAM read issued;
  - cycle 1: read data available;
  - cycle 2: sum written.
  - Full throughput of 1 sample per cycle.
- Last input sample to first `out_valid_o`: 4 cycles (2 pipeline + DRAIN exit + 1 RAM read).
- Readout uses a 2-entry prefetch FIFO so that `out_ready_i` held high gives 1 word per cycle. Low ready stalls without loss.
- `out_data_o` and `out_last_o` are stable while valid && !ready.
- `busy_o` rises the cycle after `start_i`. It falls in the same cycle `done_o` pulses.

## Configuration
- `PSD_ACC_SATURATE_EN` defined: an addition exceeding 2^`ACC_W`−1 stores 2^`ACC_W`−1 and sets `ovf_o`.
- `PSD_ACC_SATURATE_EN` undefined: additions wrap modulo 2^`ACC_W`, and `ovf_o` is tied to 0.

## Test plan
- Basic accumulation:
  - Config: `NOF_BINS`=2, `FFT_LEN_LOG2`=3, `acc_count`=4.
  - Stimulus: each frame carries data = 10·bin + point + 1.
  - Required: 16 words out with value 4·(10·bin+point+1); `out_last_o` on word 15; `done_o` 1 cycle later.
- Backpressure: same run with `out_ready_i` toggled in a 1-on/2-off pattern. Required: identical 16-word sequence with no duplicates or drops, and data held while stalled.
- Framing:
  - sop inserted at point 5 of bin 0 in pulse 2: `sync_err_o`=1; accumulation resynchronises; bin 1 results are unaffected.
  - Samples before the first sop are discarded.
- Overflow: `ACC_W`=`DATA_W`=8, `acc_count`=2, data 200.
  - With the macro: output 255, `ovf_o`=1.
  - Without the macro: output 144, `ovf_o`=0.
- Control corners:
  - `acc_count`=0 behaves as 1.
  - `start_i` during ACCUM is ignored.
  - `abort_i` in READOUT returns to IDLE next cycle, with `out_valid_o`=0.
  - `rst_n_i` low mid-ACCUM clears all outputs, and a fresh run is then correct.
